// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer register file and its
// pending-write scoreboard.
package riscv_pkg;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/riscv_rf_sb_if.sv
// Control bundle between the register file top and its scoreboard.
// Handshake: no valid/ready here; issue_valid qualifies the issue fields and
// wb_regwrite qualifies wb_rdaddr, both sampled on the same clock edge.
interface riscv_rf_sb_if #(
    parameter int AW    = riscv_pkg::AW,
    parameter int NREGS = riscv_pkg::NREGS
);
    logic             wb_regwrite;
    logic [AW-1:0]    wb_rdaddr;
    logic [AW-1:0]    rs1addr;
    logic [AW-1:0]    rs2addr;
    logic             rs1used;
    logic             rs2used;
    logic             issue_valid;
    logic             issue_longlat;
    logic [AW-1:0]    issue_rdaddr;
    logic             flush;
    logic             hazard_stall;
    logic [NREGS-1:0] pending;

    modport master (
        output wb_regwrite, wb_rdaddr, rs1addr, rs2addr, rs1used, rs2used,
               issue_valid, issue_longlat, issue_rdaddr, flush,
        input  hazard_stall, pending
    );

    modport slave (
        input  wb_regwrite, wb_rdaddr, rs1addr, rs2addr, rs1used, rs2used,
               issue_valid, issue_longlat, issue_rdaddr, flush,
        output hazard_stall, pending
    );
endinterface

// File: rtl/riscv_scoreboard.sv
// Pending-write bitmap for long-latency destinations and the RAW stall that
// holds decode until the matching writeback arrives.
module riscv_scoreboard
    import riscv_pkg::*;
#(
    parameter int AW    = riscv_pkg::AW,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic          clk,
    input  logic          rst,
    riscv_rf_sb_if.slave  sb
);
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Ordering encodes priority: clear < set < flush.
    always_comb begin
        pending_d = pending_q;
        if (sb.wb_regwrite && sb.wb_rdaddr != ZERO_REG) begin
            pending_d[sb.wb_rdaddr] = 1'b0;
        end
        if (sb.issue_valid && sb.issue_longlat && sb.issue_rdaddr != ZERO_REG) begin
            pending_d[sb.issue_rdaddr] = 1'b1;
        end
        if (sb.flush) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    logic rs1_haz;
    logic rs2_haz;

    // A same-cycle writeback to the source is resolved by the read bypass.
    always_comb begin
        rs1_haz = sb.rs1used && (sb.rs1addr != ZERO_REG) && pending_q[sb.rs1addr]
                  && !(sb.wb_regwrite && sb.wb_rdaddr == sb.rs1addr);
        rs2_haz = sb.rs2used && (sb.rs2addr != ZERO_REG) && pending_q[sb.rs2addr]
                  && !(sb.wb_regwrite && sb.wb_rdaddr == sb.rs2addr);
    end

    assign sb.hazard_stall = (rs1_haz || rs2_haz) && !sb.flush;
    assign sb.pending      = pending_q;
endmodule

// File: rtl/riscv_rf_sb.sv
// Integer register file with two bypassed read ports, fed by writeback,
// plus the long-latency scoreboard that generates decode RAW stalls.
module riscv_rf_sb
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int AW    = riscv_pkg::AW
) (
    input  logic             i_riscv_rf_clk,
    input  logic             i_riscv_rf_rst,
    input  logic             i_riscv_rf_wb_regwrite,
    input  logic [AW-1:0]    i_riscv_rf_wb_rdaddr,
    input  logic [XLEN-1:0]  i_riscv_rf_wb_rddata,
    input  logic [AW-1:0]    i_riscv_rf_rs1addr,
    input  logic [AW-1:0]    i_riscv_rf_rs2addr,
    input  logic             i_riscv_rf_rs1used,
    input  logic             i_riscv_rf_rs2used,
    input  logic             i_riscv_rf_issue_valid,
    input  logic             i_riscv_rf_issue_longlat,
    input  logic [AW-1:0]    i_riscv_rf_issue_rdaddr,
    input  logic             i_riscv_rf_flush,
    output logic [XLEN-1:0]  o_riscv_rf_rs1data,
    output logic [XLEN-1:0]  o_riscv_rf_rs2data,
    output logic             o_riscv_rf_hazard_stall,
    output logic [NREGS-1:0] o_riscv_rf_pending
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wb_en;

    assign wb_en = i_riscv_rf_wb_regwrite && (i_riscv_rf_wb_rdaddr != ZERO_REG);

    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[i_riscv_rf_wb_rdaddr] = i_riscv_rf_wb_rddata;
        end
    end

    always_ff @(posedge i_riscv_rf_clk) begin
        if (i_riscv_rf_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 is never written, but forcing zero keeps reads independent of that.
    always_comb begin
        o_riscv_rf_rs1data = regs_q[i_riscv_rf_rs1addr];
        if (i_riscv_rf_rs1addr == ZERO_REG) begin
            o_riscv_rf_rs1data = '0;
        end else if (wb_en && i_riscv_rf_wb_rdaddr == i_riscv_rf_rs1addr) begin
            o_riscv_rf_rs1data = i_riscv_rf_wb_rddata;
        end
    end

    always_comb begin
        o_riscv_rf_rs2data = regs_q[i_riscv_rf_rs2addr];
        if (i_riscv_rf_rs2addr == ZERO_REG) begin
            o_riscv_rf_rs2data = '0;
        end else if (wb_en && i_riscv_rf_wb_rdaddr == i_riscv_rf_rs2addr) begin
            o_riscv_rf_rs2data = i_riscv_rf_wb_rddata;
        end
    end

    riscv_rf_sb_if #(.AW(AW), .NREGS(NREGS)) sb_if ();

    assign sb_if.wb_regwrite   = i_riscv_rf_wb_regwrite;
    assign sb_if.wb_rdaddr     = i_riscv_rf_wb_rdaddr;
    assign sb_if.rs1addr       = i_riscv_rf_rs1addr;
    assign sb_if.rs2addr       = i_riscv_rf_rs2addr;
    assign sb_if.rs1used       = i_riscv_rf_rs1used;
    assign sb_if.rs2used       = i_riscv_rf_rs2used;
    assign sb_if.issue_valid   = i_riscv_rf_issue_valid;
    assign sb_if.issue_longlat = i_riscv_rf_issue_longlat;
    assign sb_if.issue_rdaddr  = i_riscv_rf_issue_rdaddr;
    assign sb_if.flush         = i_riscv_rf_flush;

    riscv_scoreboard #(.AW(AW), .NREGS(NREGS)) u_scoreboard (
        .clk (i_riscv_rf_clk),
        .rst (i_riscv_rf_rst),
        .sb  (sb_if.slave)
    );

    assign o_riscv_rf_hazard_stall = sb_if.hazard_stall;
    assign o_riscv_rf_pending      = sb_if.pending;
endmodule

// File: tb/tb_riscv_rf_sb.sv
// Bench for riscv_rf_sb: directed scenarios followed by random traffic, all
// checked against an array-based model of the register file and scoreboard.
module tb_riscv_rf_sb;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_rf_sb_if #(.AW(AW), .NREGS(NREGS)) tb_if ();
    logic [XLEN-1:0] wb_rddata;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;

    riscv_rf_sb dut (
        .i_riscv_rf_clk           (clk),
        .i_riscv_rf_rst           (rst),
        .i_riscv_rf_wb_regwrite   (tb_if.wb_regwrite),
        .i_riscv_rf_wb_rdaddr     (tb_if.wb_rdaddr),
        .i_riscv_rf_wb_rddata     (wb_rddata),
        .i_riscv_rf_rs1addr       (tb_if.rs1addr),
        .i_riscv_rf_rs2addr       (tb_if.rs2addr),
        .i_riscv_rf_rs1used       (tb_if.rs1used),
        .i_riscv_rf_rs2used       (tb_if.rs2used),
        .i_riscv_rf_issue_valid   (tb_if.issue_valid),
        .i_riscv_rf_issue_longlat (tb_if.issue_longlat),
        .i_riscv_rf_issue_rdaddr  (tb_if.issue_rdaddr),
        .i_riscv_rf_flush         (tb_if.flush),
        .o_riscv_rf_rs1data       (rs1data),
        .o_riscv_rf_rs2data       (rs2data),
        .o_riscv_rf_hazard_stall  (tb_if.hazard_stall),
        .o_riscv_rf_pending       (tb_if.pending)
    );

    // Reference model: architectural register values and a per-register
    // "awaiting long-latency result" flag.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] model_read(input int a);
        if (a == 0) return '0;
        if (tb_if.wb_regwrite && int'(tb_if.wb_rdaddr) == a) return wb_rddata;
        return m_regs[a];
    endfunction

    function automatic bit model_src_waits(input bit used, input int a);
        if (!used || a == 0 || !m_pend[a]) return 1'b0;
        return !(tb_if.wb_regwrite && int'(tb_if.wb_rdaddr) == a);
    endfunction

    task automatic idle();
        rst                 = 1'b0;
        tb_if.wb_regwrite   = 1'b0;
        tb_if.wb_rdaddr     = '0;
        wb_rddata           = '0;
        tb_if.rs1addr       = '0;
        tb_if.rs2addr       = '0;
        tb_if.rs1used       = 1'b0;
        tb_if.rs2used       = 1'b0;
        tb_if.issue_valid   = 1'b0;
        tb_if.issue_longlat = 1'b0;
        tb_if.issue_rdaddr  = '0;
        tb_if.flush         = 1'b0;
    endtask

    task automatic wb(input int a, input logic [XLEN-1:0] d);
        tb_if.wb_regwrite = 1'b1;
        tb_if.wb_rdaddr   = AW'(a);
        wb_rddata         = d;
    endtask

    task automatic issue_ll(input int a);
        tb_if.issue_valid   = 1'b1;
        tb_if.issue_longlat = 1'b1;
        tb_if.issue_rdaddr  = AW'(a);
    endtask

    // Inputs are already applied (at negedge); check combinational outputs,
    // take the clock edge, and advance the model.
    task automatic step();
        logic [NREGS-1:0] exp_pend;
        bit               exp_stall;
        #2;
        for (int i = 0; i < NREGS; i++) exp_pend[i] = m_pend[i];
        exp_stall = (model_src_waits(tb_if.rs1used, int'(tb_if.rs1addr)) ||
                     model_src_waits(tb_if.rs2used, int'(tb_if.rs2addr))) && !tb_if.flush;
        check("rs1data", rs1data, model_read(int'(tb_if.rs1addr)));
        check("rs2data", rs2data, model_read(int'(tb_if.rs2addr)));
        check("hazard_stall", XLEN'(tb_if.hazard_stall), XLEN'(exp_stall));
        check("pending", XLEN'(tb_if.pending), XLEN'(exp_pend));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            int w = int'(tb_if.wb_rdaddr);
            int s = int'(tb_if.issue_rdaddr);
            if (tb_if.wb_regwrite && w != 0) begin
                m_regs[w] = wb_rddata;
                m_pend[w] = 1'b0;
            end
            if (tb_if.issue_valid && tb_if.issue_longlat && s != 0) m_pend[s] = 1'b1;
            if (tb_if.flush) begin
                for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        @(negedge clk);

        // Reset state and x0
        idle(); tb_if.rs1addr = 5'd1; tb_if.rs2addr = 5'd31; step();
        idle(); wb(0, 64'hDEAD); step();
        idle(); step();

        // Bypass then stored value
        idle(); wb(5, 64'h1122334455667788); tb_if.rs1addr = 5'd5; tb_if.rs2addr = 5'd5; step();
        idle(); tb_if.rs1addr = 5'd5; step();

        // Load to x7, consumer stalls until writeback
        idle(); issue_ll(7); step();
        for (int k = 0; k < 3; k++) begin
            idle(); tb_if.rs2addr = 5'd7; tb_if.rs2used = 1'b1; step();
        end
        idle(); tb_if.rs2addr = 5'd7; tb_if.rs2used = 1'b1; wb(7, 64'h42); step();
        idle(); tb_if.rs2addr = 5'd7; tb_if.rs2used = 1'b1; step();

        // Set wins over clear on the same register
        idle(); wb(9, 64'h99); issue_ll(9); step();
        idle(); tb_if.rs1addr = 5'd9; step();
        idle(); tb_if.rs1addr = 5'd9; tb_if.rs1used = 1'b1; step();
        idle(); wb(9, 64'h100); step();

        // Flush clears everything and blocks a concurrent set
        idle(); issue_ll(3); step();
        idle(); issue_ll(4); step();
        idle(); issue_ll(12); step();
        idle(); tb_if.flush = 1'b1; tb_if.rs1addr = 5'd3; tb_if.rs1used = 1'b1;
        issue_ll(20); step();
        idle(); tb_if.rs1addr = 5'd3; tb_if.rs1used = 1'b1; step();

        // Reset mid-stall
        idle(); wb(10, 64'h5); step();
        idle(); issue_ll(10); step();
        idle(); tb_if.rs1addr = 5'd10; tb_if.rs1used = 1'b1; step();
        idle(); rst = 1'b1; tb_if.rs1addr = 5'd10; tb_if.rs1used = 1'b1;
        wb(11, 64'h77); step();
        idle(); tb_if.rs1addr = 5'd10; tb_if.rs1used = 1'b1; tb_if.rs2addr = 5'd11; step();

        // Random traffic on a narrow register window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            rst                 = ($urandom_range(0, 99) == 0);
            tb_if.rs1addr       = AW'($urandom_range(0, 7));
            tb_if.rs2addr       = AW'($urandom_range(0, 7));
            tb_if.rs1used       = $urandom_range(0, 3) != 0;
            tb_if.rs2used       = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 1) == 1) wb($urandom_range(0, 7), {$urandom, $urandom});
            tb_if.issue_valid   = $urandom_range(0, 1) == 1;
            tb_if.issue_longlat = $urandom_range(0, 4) < 3;
            tb_if.issue_rdaddr  = AW'($urandom_range(0, 7));
            tb_if.flush         = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/riscv_rf_sb.md
Name: riscv_rf_sb

Overview:
- Receiving end of the writeback path: integer register file plus pending-write scoreboard.
- Consumes the writeback data/address/enable produced at the end of the pipeline.
- Serves two decode-stage read ports with same-cycle writeback bypass.
- Tracks long-latency destinations (load, mul, div, AMO/SC) and raises a stall for RAW hazards until the matching writeback arrives. Trap flush clears tracking.

Parameters:
- XLEN, 64, register width in bits.
- NREGS, 32, number of architectural integer registers.
- AW, 5, register address width (clog2 NREGS).

Ports:
- i_riscv_rf_clk  in  1  core clock
- i_riscv_rf_rst  in  1  synchronous reset, active-high
- i_riscv_rf_wb_regwrite  in  1  writeback write enable
- i_riscv_rf_wb_rdaddr  in  AW  writeback destination
- i_riscv_rf_wb_rddata  in  XLEN  writeback data (final result/CSR mux output)
- i_riscv_rf_rs1addr  in  AW  decode read address 1
- i_riscv_rf_rs2addr  in  AW  decode read address 2
- i_riscv_rf_rs1used  in  1  decode instruction actually reads rs1
- i_riscv_rf_rs2used  in  1  decode instruction actually reads rs2
- i_riscv_rf_issue_valid  in  1  decode instruction advances this cycle (not stalled, not flushed)
- i_riscv_rf_issue_longlat  in  1  issuing instruction is long-latency
- i_riscv_rf_issue_rdaddr  in  AW  issuing instruction destination
- i_riscv_rf_flush  in  1  trap/return flush from writeback trap logic
- o_riscv_rf_rs1data  out  XLEN  read data 1
- o_riscv_rf_rs2data  out  XLEN  read data 2
- o_riscv_rf_hazard_stall  out  1  RAW hazard on a pending long-latency register
- o_riscv_rf_pending  out  NREGS  pending bitmap (debug/verification)

Behaviour:
- Reset, on the clock edge while rst=1: all registers 0, pending bitmap 0. Result: rs1data=rs2data=0, hazard_stall=0, pending=0. Reset mid-operation drops any in-flight writeback that cycle.
- Write: on posedge, if regwrite=1 and rdaddr!=0, reg[rdaddr] <= rddata. Writes to x0 are ignored. x0 always reads 0.
- Read: combinational, 0-cycle.
  - If regwrite=1, rdaddr==rsNaddr and rsNaddr!=0, output wb_rddata (bypass).
  - Otherwise output reg[rsNaddr].
  - Both ports may bypass the same writeback at once.
- Pending set: on posedge, if issue_valid=1, issue_longlat=1, issue_rdaddr!=0 and flush=0, set pending[issue_rdaddr].
- Pending clear: on posedge, if regwrite=1 and rdaddr!=0, clear pending[rdaddr].
- Same register set and cleared in one cycle: set wins, because the new instruction owns rd.
- Flush=1: pending <= 0 on that edge, overriding set and clear. The writeback data in the flush cycle is still written; the trap logic gates regwrite itself.
- hazard_stall (combinational) = OR over N in {1,2} of (rsNused & rsNaddr!=0 & pending[rsNaddr] & ~(regwrite & rdaddr==rsNaddr)). A writeback arriving in the same cycle resolves the hazard through the bypass.
- hazard_stall is forced 0 when flush=1.
- No counters and no overflow: one outstanding long-latency write per register. A second issue to a pending rd only re-sets an already-set bit. WAW ordering is guaranteed by the in-order pipeline.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, NREGS, AW constants.
  - ZERO_REG (5'd0) localparam.
  - Typedef reg_addr_t.
- Sub-module riscv_scoreboard:
  - Holds the pending bitmap, set/clear/flush priority and hazard_stall logic.
  - Inputs: the issue, writeback and read-address ports above.
- Top riscv_rf_sb: register array, write logic, bypass read muxes, scoreboard instance.

Test Plan:
- Reset then read x1/x31 -> rs1data=rs2data=0, pending=0, stall=0. Write x0=0xDEAD -> x0 still reads 0.
- WB write x5=0x1122334455667788 while rs1addr=5 in the same cycle -> rs1data=0x1122334455667788 that cycle (bypass) and the next (stored).
- Issue load rd=7 (longlat); next cycle rs2addr=7, rs2used=1 -> stall=1. Hold 3 cycles, then WB x7=0x42 -> stall=0 and rs2data=0x42 in the same cycle; pending[7]=0 after the edge.
- Same cycle: WB clears x9 and issue longlat rd=9 -> pending[9]=1 after the edge. rs1addr=9 with rs1used=0 -> stall=0.
- Pending {3,4,12} set, assert flush -> pending=0 next cycle, stall=0 during flush. A longlat issue during flush does not set its bit.
- Assert rst mid-stall with x10 pending and x10=0x5 -> pending=0, reg[10]=0, stall=0 after the edge.
